cci_mpf_shim_buffer_afu_nch: RTL

N-channel, latency-insensitive request buffer for the AFU side of MPF shims. It generalises the two-channel AFU buffer to the following:
- N_CHANNELS independent channels, each with a DATA_WIDTH payload.
- A per-channel bypass mask.
- Occupancy outputs.
- Sticky protocol-error flags.
- A flush/drain state machine.

Shims instantiate it between afu_raw-style request wires and their internal pipeline. It breaks almost-full combinational loops and lets a shim quiesce all request channels before reconfiguration.

---
 rtl/cci_mpf_shim_buffer_afu_nch.sv | 126 ++++++++++++
 1 files changed

// File: rtl/cci_mpf_shim_buffer_afu_nch.sv
// N-channel AFU-side request buffer: per-channel FIFOs with optional bypass, sticky
// error flags and a flush/drain FSM. Define CCI_MPF_SHIM_BUFFER_STATS_EN for stall counters.
module cci_mpf_shim_buffer_afu_nch #(
  parameter int                    N_CHANNELS  = 2,
  parameter int                    DATA_WIDTH  = 64,
  parameter int                    N_ENTRIES   = 6,
  parameter int                    THRESHOLD   = 4,
  parameter logic [N_CHANNELS-1:0] BYPASS_MASK = '0,
  localparam int                   CNT_W       = $clog2(N_ENTRIES + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N_CHANNELS-1:0]            enq_en,
  input  logic [N_CHANNELS*DATA_WIDTH-1:0] enq_data,
  output logic [N_CHANNELS-1:0]            almost_full,
  output logic [N_CHANNELS*DATA_WIDTH-1:0] first,
  output logic [N_CHANNELS-1:0]            not_empty,
  input  logic [N_CHANNELS-1:0]            deq_en,
  output logic [N_CHANNELS*CNT_W-1:0]      count,
  input  logic                             flush_req,
  output logic                             flush_busy,
  output logic                             flush_done,
  output logic [N_CHANNELS-1:0]            overflow,
  output logic [N_CHANNELS-1:0]            underflow,
  output logic [N_CHANNELS*32-1:0]         stall_cycles
);

  typedef enum logic [1:0] {
    FL_IDLE,
    FL_DRAIN,
    FL_DONE
  } flush_state_t;

  flush_state_t          fl_state, fl_next;
  logic [N_CHANNELS-1:0] chan_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fl_state <= FL_IDLE;
    else       fl_state <= fl_next;
  end

  always_comb begin
    fl_next    = fl_state;
    flush_busy = 1'b0;
    flush_done = 1'b0;
    unique case (fl_state)
      FL_IDLE:  if (flush_req) fl_next = FL_DRAIN;
      FL_DRAIN: begin
        flush_busy = 1'b1;
        // In-flight enqueues are still accepted, so completion also waits for a quiet enq cycle
        if (&chan_empty && (enq_en == '0)) fl_next = FL_DONE;
      end
      FL_DONE: begin
        flush_done = 1'b1;
        fl_next    = FL_IDLE;
      end
      default:  fl_next = FL_IDLE;
    endcase
  end

  for (genvar g = 0; g < N_CHANNELS; g++) begin : g_chan
    localparam int PTR_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

    logic [DATA_WIDTH-1:0] mem [N_ENTRIES];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] din;
    logic                  fifo_ne, full, pass, do_enq, do_deq;
    logic                  ovf, udf;

    assign din     = enq_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign fifo_ne = (cnt != '0);
    assign full    = (cnt == CNT_W'(N_ENTRIES));
    // Pass-through only when the FIFO is empty, so ordering is preserved
    assign pass    = BYPASS_MASK[g] && !fifo_ne && enq_en[g] && deq_en[g];
    assign do_deq  = deq_en[g] && fifo_ne;
    assign do_enq  = enq_en[g] && !pass && (!full || do_deq);

    assign not_empty[g] = fifo_ne || (BYPASS_MASK[g] && enq_en[g]);
    assign first[g*DATA_WIDTH +: DATA_WIDTH] =
      (fifo_ne || !BYPASS_MASK[g]) ? mem[rd_ptr] : din;
    assign count[g*CNT_W +: CNT_W] = cnt;
    assign chan_empty[g]  = !fifo_ne;
    assign almost_full[g] = ((N_ENTRIES - int'(cnt)) <= THRESHOLD) || flush_busy;
    assign overflow[g]    = ovf;
    assign underflow[g]   = udf;

    always_ff @(posedge clk) begin
      if (do_enq) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
        ovf    <= 1'b0;
        udf    <= 1'b0;
      end else begin
        if (do_enq) wr_ptr <= (wr_ptr == PTR_W'(N_ENTRIES - 1)) ? '0 : wr_ptr + 1'b1;
        if (do_deq) rd_ptr <= (rd_ptr == PTR_W'(N_ENTRIES - 1)) ? '0 : rd_ptr + 1'b1;
        unique case ({do_enq, do_deq})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: ;
        endcase
        if (enq_en[g] && full && !deq_en[g]) ovf <= 1'b1;
        if (deq_en[g] && !not_empty[g])      udf <= 1'b1;
      end
    end

`ifdef CCI_MPF_SHIM_BUFFER_STATS_EN
    logic [31:0] stall;

    always_ff @(posedge clk or posedge reset) begin
      if (reset)                              stall <= '0;
      else if (almost_full[g] && stall != '1) stall <= stall + 1'b1;
    end

    assign stall_cycles[g*32 +: 32] = stall;
`else
    assign stall_cycles[g*32 +: 32] = '0;
`endif
  end

endmodule
